// File: rtl/mgmt_phy_controller.sv
// mgmt_phy_controller: link bring-up FSM (comma hunt, detect, speed, advertise, configure, operational).
// Optional MGMT_PHY_CTRL_CONFIG_RETRY_LIMIT_EN: bound CONFIGURE timeouts to 8 before declaring link lost.
`default_nettype none

module mgmt_phy_controller #(
  parameter logic [3:0]  FRAME_LENGTH = 4'd15,
  parameter logic [15:0] TIMER_1MS    = 16'd60000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       aligned,
  input  logic       frame_crc_err,
  input  logic       crc_consec_loss,
  input  logic       unexpected_frame_error,
  input  logic       link_detect_locked,
  input  logic       detect_255_sent,
  input  logic       link_speed_locked,
  input  logic       link_speed_timeout,
  input  logic       advertise_locked,
  input  logic       accept_frm_recv,
  input  logic [3:0] tx_frm_offset,
  input  logic       change_freq_st,
  input  logic       pll_configuration_done,
  input  logic       local_software_reset,
  input  logic       remote_software_reset,
  input  logic       auto_move_config,
  input  logic       trigger_config_st,
  output logic       pll_reconfig,
  output logic       configure_send,
  output logic [3:0] link_state
);

  typedef enum logic [3:0] {
    ST_INIT              = 4'd0,
    ST_COMMA_HUNTING     = 4'd1,
    ST_DETECT            = 4'd2,
    ST_SPEED             = 4'd3,
    ST_SPEED_CHANGE      = 4'd4,
    ST_ADVERTISE         = 4'd5,
    ST_WAIT_IN_ADVERTISE = 4'd6,
    ST_CONFIGURE         = 4'd7,
    ST_OPERATIONAL       = 4'd8,
    ST_OPERATIONAL_RESET = 4'd9,
    ST_LINK_LOST         = 4'd10
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] timer_q, timer_d;
  logic        pll_reconfig_q, configure_send_q;
  logic [3:0]  link_state_q;
  logic        err, fe, timer_done, timer_run;

`ifdef MGMT_PHY_CTRL_CONFIG_RETRY_LIMIT_EN
  logic [2:0]  retry_q, retry_d;
`endif

  assign err        = crc_consec_loss | (unexpected_frame_error & ~frame_crc_err);
  assign fe         = (tx_frm_offset == FRAME_LENGTH);
  assign timer_done = (timer_q >= TIMER_1MS);

  always_comb begin
    state_d   = state_q;
    timer_run = 1'b0;
`ifdef MGMT_PHY_CTRL_CONFIG_RETRY_LIMIT_EN
    retry_d   = retry_q;
`endif
    case (state_q)
      ST_INIT: if (pll_configuration_done) state_d = ST_COMMA_HUNTING;
      ST_COMMA_HUNTING: begin
        if (aligned) begin
          state_d = change_freq_st ? ST_ADVERTISE : ST_DETECT;
        end else if (change_freq_st) begin
          timer_run = 1'b1;
          if (timer_done) state_d = ST_LINK_LOST;
        end
      end
      ST_DETECT: begin
        if (err) state_d = ST_LINK_LOST;
        else if (link_detect_locked && detect_255_sent && fe) state_d = ST_SPEED;
      end
      ST_SPEED: begin
        if (err || link_speed_timeout) state_d = ST_LINK_LOST;
        else if (link_speed_locked && fe) state_d = ST_SPEED_CHANGE;
      end
      // The PLL wrapper resets this block once the new frequency is up.
      ST_SPEED_CHANGE: state_d = ST_SPEED_CHANGE;
      ST_ADVERTISE: begin
        timer_run = 1'b1;
        if (err) state_d = ST_LINK_LOST;
        else if (timer_done) begin
          if (!advertise_locked) state_d = ST_LINK_LOST;
          else if (!auto_move_config) state_d = ST_WAIT_IN_ADVERTISE;
          else if (fe) state_d = ST_CONFIGURE;
        end
      end
      ST_WAIT_IN_ADVERTISE: begin
        if (err) state_d = ST_LINK_LOST;
        else if (trigger_config_st && fe) state_d = ST_CONFIGURE;
      end
      ST_CONFIGURE: begin
        timer_run = 1'b1;
        if (err) state_d = ST_LINK_LOST;
        else if (accept_frm_recv) begin
          if (fe) state_d = ST_OPERATIONAL;
        end else if (timer_done && fe) begin
`ifdef MGMT_PHY_CTRL_CONFIG_RETRY_LIMIT_EN
          if (retry_q == 3'd7) begin
            state_d = ST_LINK_LOST;
          end else begin
            state_d = ST_ADVERTISE;
            retry_d = retry_q + 3'd1;
          end
`else
          state_d = ST_ADVERTISE;
`endif
        end
      end
      ST_OPERATIONAL: begin
        if (err) state_d = ST_LINK_LOST;
        else if (local_software_reset || remote_software_reset) state_d = ST_OPERATIONAL_RESET;
      end
      ST_OPERATIONAL_RESET: if (fe) state_d = ST_ADVERTISE;
      ST_LINK_LOST: state_d = ST_INIT;
      default: state_d = ST_INIT;
    endcase

`ifdef MGMT_PHY_CTRL_CONFIG_RETRY_LIMIT_EN
    if (state_d == ST_OPERATIONAL || state_d == ST_INIT) retry_d = 3'd0;
`endif

    // Timer restarts on every state change and saturates once done.
    if (!timer_run || state_d != state_q) timer_d = 16'd0;
    else if (timer_done) timer_d = timer_q;
    else timer_d = timer_q + 16'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= ST_INIT;
      timer_q          <= 16'd0;
      pll_reconfig_q   <= 1'b0;
      configure_send_q <= 1'b0;
      link_state_q     <= 4'd0;
`ifdef MGMT_PHY_CTRL_CONFIG_RETRY_LIMIT_EN
      retry_q          <= 3'd0;
`endif
    end else begin
      state_q          <= state_d;
      timer_q          <= timer_d;
      pll_reconfig_q   <= (state_d == ST_INIT) || (state_d == ST_SPEED_CHANGE);
      configure_send_q <= (state_d == ST_CONFIGURE);
      link_state_q     <= state_d;
`ifdef MGMT_PHY_CTRL_CONFIG_RETRY_LIMIT_EN
      retry_q          <= retry_d;
`endif
    end
  end

  assign pll_reconfig   = pll_reconfig_q;
  assign configure_send = configure_send_q;
  assign link_state     = link_state_q;

endmodule

`default_nettype wire

// File: doc/mgmt_phy_controller.md
MGMT_PHY_CONTROLLER -- requirements
Module: mgmt_phy_controller

Interface
REQ-001 FRAME_LENGTH, 4'd15, tx_frm_offset value of last byte of a frame (frame boundary).
REQ-002 TIMER_1MS, 16'd60000, clk cycles per 1 ms window.
REQ-003 clk  in  1  clock; all logic on rising edge.
REQ-004 reset  in  1  asynchronous, active-high.
REQ-005 aligned  in  1  RX comma alignment achieved.
REQ-006 frame_crc_err  in  1  current RX frame failed CRC.
REQ-007 crc_consec_loss  in  1  consecutive-CRC-loss threshold hit.
REQ-008 unexpected_frame_error  in  1  RX frame type illegal for current state.
REQ-009 link_detect_locked  in  1  remote Detect frames locked.
REQ-010 detect_255_sent  in  1  255 Detect frames transmitted.
REQ-011 link_speed_locked  in  1  remote Speed frames locked.
REQ-012 link_speed_timeout  in  1  Speed phase timeout.
REQ-013 advertise_locked  in  1  remote Advertise frames locked.
REQ-014 accept_frm_recv  in  1  Accept frame received from target.
REQ-015 tx_frm_offset  in  4  TX byte offset in current frame.
REQ-016 change_freq_st  in  1  PLL running at operational frequency.
REQ-017 pll_configuration_done  in  1  PLL reconfiguration complete.
REQ-018 local_software_reset  in  1  CSR software reset.
REQ-019 remote_software_reset  in  1  software reset flag from target.
REQ-020 auto_move_config  in  1  CSR: leave Advertise automatically.
REQ-021 trigger_config_st  in  1  CSR: manual move to Configure.
REQ-022 pll_reconfig  out  1  request PLL reconfiguration.
REQ-023 configure_send  out  1  TX must emit Configure frames.
REQ-024 link_state  out  4  current state code.

Function
REQ-025 Codes: INIT=0, COMMA_HUNTING=1, DETECT=2, SPEED=3, SPEED_CHANGE=4, ADVERTISE=5, WAIT_IN_ADVERTISE=6, CONFIGURE=7, OPERATIONAL=8, OPERATIONAL_RESET=9, LINK_LOST=10; other codes -> INIT next cycle.
REQ-026 err = crc_consec_loss | (unexpected_frame_error & !frame_crc_err); fe = (tx_frm_offset == FRAME_LENGTH); transitions marked [fe] fire only when fe=1, otherwise hold.
REQ-027 INIT: pll_reconfig=1 until pll_configuration_done=1, then pll_reconfig=0 and -> COMMA_HUNTING same edge.
REQ-028 COMMA_HUNTING: aligned & !change_freq_st -> DETECT; aligned & change_freq_st -> ADVERTISE; change_freq_st & !aligned for TIMER_1MS cycles -> LINK_LOST.
REQ-029 DETECT: err -> LINK_LOST; link_detect_locked & detect_255_sent -> SPEED [fe].
REQ-030 SPEED: err | link_speed_timeout -> LINK_LOST; link_speed_locked -> SPEED_CHANGE [fe].
REQ-031 SPEED_CHANGE: pll_reconfig=1 held; state left only via reset (PLL wrapper resets block after reconfig).
REQ-032 ADVERTISE: timer runs; err -> LINK_LOST; timer done & !advertise_locked -> LINK_LOST; timer done & advertise_locked -> CONFIGURE [fe] if auto_move_config else WAIT_IN_ADVERTISE.
REQ-033 WAIT_IN_ADVERTISE: timer cleared; err -> LINK_LOST; trigger_config_st -> CONFIGURE [fe].
REQ-034 CONFIGURE: configure_send=1, timer runs; err -> LINK_LOST; accept_frm_recv -> OPERATIONAL [fe]; timer done without accept -> ADVERTISE [fe] (timer restarts).
REQ-035 OPERATIONAL: priority err -> LINK_LOST, then local|remote software reset -> OPERATIONAL_RESET.
REQ-036 OPERATIONAL_RESET: -> ADVERTISE [fe]; LINK_LOST: -> INIT next cycle.
REQ-037 err has priority over every other same-cycle event in all states using it.
REQ-038 Timer: 16-bit, cleared whenever timer not running or state changes; done=1 from cycle TIMER_1MS after start, saturates.
REQ-039 configure_send=1 only in CONFIGURE; link_state registered, equal to state code.

Reset
REQ-040 On reset: state INIT, pll_reconfig=0, configure_send=0, link_state=0, timer=0, retry count=0.
REQ-041 Reset mid-operation (any state) aborts immediately; no output glitch beyond reset values.

Configuration
REQ-042 MGMT_PHY_CTRL_CONFIG_RETRY_LIMIT_EN defined: 3-bit retry counter increments on each CONFIGURE->ADVERTISE timeout; 8th timeout -> LINK_LOST instead; counter cleared on entering OPERATIONAL or INIT.
REQ-043 Macro undefined: no counter; CONFIGURE timeouts return to ADVERTISE indefinitely.

Verification
REQ-044 TIMER_1MS=100: done=1 at reset release, aligned=1, change_freq_st=0 -> link_state 0->1->2 on consecutive edges.
REQ-045 DETECT, locked+255 sent, tx_frm_offset=7 -> hold at 2; offset=15 -> 3 next edge.
REQ-046 ADVERTISE, advertise_locked=1, auto_move_config=1, fe=1 -> 7 after 100 cycles, configure_send=1; accept_frm_recv -> 8.
REQ-047 OPERATIONAL, crc_consec_loss and local_software_reset same cycle -> 10 then 0.
REQ-048 CONFIGURE, no accept, macro defined -> 8 timeouts then 10; undefined -> 5/7 cycling after 20 timeouts.
